branch_target_table: RTL and testbench

Programmable, parametrised branch-target unit for the fetch stage. It replaces the fixed combinational label table with three pieces of state: a run-time writable target table with per-entry valid and absolute/PC-relative mode bits, a return-address stack for call/return, and a registered one-cycle response. Fetch issues one request per cycle and loads the PC from `target` when `redirect` is high.

---
 rtl/branch_target_table.sv | 140 ++++++++++++++
 tb/tb_branch_target_table.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_table.sv
// Fetch-stage branch-target unit: writable target table, circular return-address
// stack and a registered one-cycle redirect response.
module branch_target_table #(
  parameter int unsigned D        = 8,
  parameter int unsigned A        = 5,
  parameter int unsigned RS_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              wr_en,
  input  logic [A-1:0]                      wr_idx,
  input  logic [D-1:0]                      wr_target,
  input  logic                              wr_rel,
  input  logic                              req,
  input  logic [1:0]                        req_kind,
  input  logic [A-1:0]                      idx,
  input  logic [D-1:0]                      pc,
  input  logic                              taken,
  output logic                              rsp_valid,
  output logic                              redirect,
  output logic [D-1:0]                      target,
  output logic                              fault,
  output logic [$clog2(RS_DEPTH+1)-1:0]     rs_count
);

  localparam int unsigned N  = 2 ** A;
  localparam int unsigned CW = $clog2(RS_DEPTH + 1);
  localparam int unsigned PW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  localparam logic [1:0] KIND_BRANCH = 2'b00;
  localparam logic [1:0] KIND_CALL   = 2'b01;
  localparam logic [1:0] KIND_RETURN = 2'b10;

  logic [N-1:0]  tbl_valid;
  logic [N-1:0]  tbl_rel;
  logic [D-1:0]  tbl_val [N];

  logic [D-1:0]  stk [RS_DEPTH];
  logic [PW-1:0] rs_ptr;

  logic          rsp_valid_n;
  logic          redirect_n;
  logic [D-1:0]  target_n;
  logic          fault_n;
  logic          push;
  logic          pop;
  logic [D-1:0]  resolved;
  logic [D-1:0]  ret_addr;
  logic [PW-1:0] ptr_prev;
  logic [PW-1:0] ptr_next;
  logic          stk_full;
  logic          stk_empty;

  assign stk_full  = (rs_count == CW'(RS_DEPTH));
  assign stk_empty = (rs_count == '0);
  assign ptr_prev  = (rs_ptr == '0) ? PW'(RS_DEPTH - 1) : PW'(rs_ptr - PW'(1));
  assign ptr_next  = (rs_ptr == PW'(RS_DEPTH - 1)) ? '0 : PW'(rs_ptr + PW'(1));
  assign resolved  = tbl_rel[idx] ? D'(pc + tbl_val[idx]) : tbl_val[idx];
  assign ret_addr  = D'(pc + D'(1));

  // Response decode; reads pre-write table contents so same-cycle writes are not seen.
  always_comb begin
    rsp_valid_n = req;
    redirect_n  = 1'b0;
    target_n    = '0;
    fault_n     = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    if (req) begin
      case (req_kind)
        KIND_BRANCH, KIND_CALL: begin
          if (taken) begin
            if (tbl_valid[idx]) begin
              redirect_n = 1'b1;
              target_n   = resolved;
              if (req_kind == KIND_CALL) begin
                push    = 1'b1;
                fault_n = stk_full;
              end
            end else begin
              fault_n = 1'b1;
            end
          end
        end
        KIND_RETURN: begin
          if (!stk_empty) begin
            pop        = 1'b1;
            redirect_n = 1'b1;
            target_n   = stk[ptr_prev];
          end else begin
            fault_n = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output registers, valid bits and stack bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      redirect  <= 1'b0;
      target    <= '0;
      fault     <= 1'b0;
      tbl_valid <= '0;
      rs_ptr    <= '0;
      rs_count  <= '0;
    end else begin
      rsp_valid <= rsp_valid_n;
      redirect  <= redirect_n;
      target    <= target_n;
      fault     <= fault_n;
      if (wr_en) begin
        tbl_valid[wr_idx] <= 1'b1;
      end
      if (push) begin
        rs_ptr <= ptr_next;
        if (!stk_full) begin
          rs_count <= CW'(rs_count + CW'(1));
        end
      end else if (pop) begin
        rs_ptr   <= ptr_prev;
        rs_count <= CW'(rs_count - CW'(1));
      end
    end
  end

  // Payload storage needs no reset: it is only read behind a valid bit or the count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tbl_rel[wr_idx] <= wr_rel;
      tbl_val[wr_idx] <= wr_target;
    end
    if (push) begin
      stk[rs_ptr] <= ret_addr;
    end
  end

endmodule

// File: tb/tb_branch_target_table.sv
// Directed self-checking bench for branch_target_table with default parameters.
module tb_branch_target_table;

  localparam int unsigned D  = 8;
  localparam int unsigned A  = 5;
  localparam int unsigned RD = 4;
  localparam int unsigned CW = $clog2(RD + 1);

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [A-1:0]  wr_idx;
  logic [D-1:0]  wr_target;
  logic          wr_rel;
  logic          req;
  logic [1:0]    req_kind;
  logic [A-1:0]  idx;
  logic [D-1:0]  pc;
  logic          taken;
  logic          rsp_valid;
  logic          redirect;
  logic [D-1:0]  target;
  logic          fault;
  logic [CW-1:0] rs_count;

  int tests_run;
  int tests_failed;

  branch_target_table #(.D(D), .A(A), .RS_DEPTH(RD)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_target (wr_target),
    .wr_rel    (wr_rel),
    .req       (req),
    .req_kind  (req_kind),
    .idx       (idx),
    .pc        (pc),
    .taken     (taken),
    .rsp_valid (rsp_valid),
    .redirect  (redirect),
    .target    (target),
    .fault     (fault),
    .rs_count  (rs_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program one entry with no lookup in the same cycle.
  task automatic do_write(input logic [A-1:0] i, input logic [D-1:0] v, input logic r);
    wr_en = 1'b1; wr_idx = i; wr_target = v; wr_rel = r; req = 1'b0;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Issue one request; returns 1 ns after the sampling edge so the response is visible.
  task automatic do_req(input logic [1:0] k, input logic [A-1:0] i, input logic [D-1:0] p,
                        input logic t);
    req = 1'b1; req_kind = k; idx = i; pc = p; taken = t;
    @(posedge clk); #1;
    req = 1'b0; wr_en = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({rsp_valid, redirect, target, fault} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_outputs: got v=%b r=%b t=%h f=%b, want all zero",
               rsp_valid, redirect, target, fault);
    end
    tests_run++;
    if (rs_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_rs_count: got %0d, want 0", rs_count);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    do_req(2'b00, 5'd3, 8'd0, 1'b1);
    tests_run++;
    if ({rsp_valid, redirect, target, fault} !== {1'b1, 1'b0, 8'h00, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_miss: got v=%b r=%b t=%h f=%b, want v=1 r=0 t=00 f=1",
               rsp_valid, redirect, target, fault);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({rsp_valid, redirect, target, fault} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      tests_failed++;
      $display("FAIL idle_outputs: got v=%b r=%b t=%h f=%b, want all zero",
               rsp_valid, redirect, target, fault);
    end
  endtask

  task automatic test_table;
    do_write(5'd1, 8'd22, 1'b0);
    do_write(5'd2, 8'hFE, 1'b1);
    do_write(5'd4, 8'h10, 1'b1);
    do_req(2'b00, 5'd1, 8'd10, 1'b1);
    tests_run++;
    if ({rsp_valid, redirect, target, fault} !== {1'b1, 1'b1, 8'd22, 1'b0}) begin
      tests_failed++;
      $display("FAIL abs_branch: got v=%b r=%b t=%0d f=%b, want v=1 r=1 t=22 f=0",
               rsp_valid, redirect, target, fault);
    end
    do_req(2'b00, 5'd2, 8'd5, 1'b1);
    tests_run++;
    if ({redirect, target, fault} !== {1'b1, 8'd3, 1'b0}) begin
      tests_failed++;
      $display("FAIL rel_branch_neg: got r=%b t=%0d f=%b, want r=1 t=3 f=0",
               redirect, target, fault);
    end
    do_req(2'b00, 5'd4, 8'hF8, 1'b1);
    tests_run++;
    if ({redirect, target, fault} !== {1'b1, 8'h08, 1'b0}) begin
      tests_failed++;
      $display("FAIL rel_branch_wrap: got r=%b t=%h f=%b, want r=1 t=08 f=0",
               redirect, target, fault);
    end
    do_req(2'b00, 5'd1, 8'd10, 1'b0);
    tests_run++;
    if ({rsp_valid, redirect, target, fault} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      tests_failed++;
      $display("FAIL not_taken: got v=%b r=%b t=%h f=%b, want v=1 r=0 t=00 f=0",
               rsp_valid, redirect, target, fault);
    end
    do_req(2'b11, 5'd1, 8'd10, 1'b1);
    tests_run++;
    if ({rsp_valid, redirect, target, fault, rs_count} !== {1'b1, 1'b0, 8'h00, 1'b0, 3'd0}) begin
      tests_failed++;
      $display("FAIL noop: got v=%b r=%b t=%h f=%b c=%0d, want v=1 r=0 t=00 f=0 c=0",
               rsp_valid, redirect, target, fault, rs_count);
    end
    do_req(2'b01, 5'd9, 8'd7, 1'b1);
    tests_run++;
    if ({redirect, fault, rs_count} !== {1'b0, 1'b1, 3'd0}) begin
      tests_failed++;
      $display("FAIL call_miss: got r=%b f=%b c=%0d, want r=0 f=1 c=0",
               redirect, fault, rs_count);
    end
  endtask

  task automatic test_call_return;
    logic [D-1:0] call_pc [3];
    logic [D-1:0] ret_exp [3];
    call_pc[0] = 8'd4;  call_pc[1] = 8'd9;  call_pc[2] = 8'd20;
    ret_exp[0] = 8'd21; ret_exp[1] = 8'd10; ret_exp[2] = 8'd5;
    for (int i = 0; i < 3; i++) begin
      do_req(2'b01, 5'd1, call_pc[i], 1'b1);
      tests_run++;
      if ({redirect, target, fault, rs_count} !== {1'b1, 8'd22, 1'b0, 3'(i + 1)}) begin
        tests_failed++;
        $display("FAIL call_%0d: got r=%b t=%0d f=%b c=%0d, want r=1 t=22 f=0 c=%0d",
                 i, redirect, target, fault, rs_count, i + 1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      do_req(2'b10, 5'd0, 8'd0, 1'b0);
      tests_run++;
      if ({redirect, target, fault, rs_count} !== {1'b1, ret_exp[i], 1'b0, 3'(2 - i)}) begin
        tests_failed++;
        $display("FAIL return_%0d: got r=%b t=%0d f=%b c=%0d, want r=1 t=%0d f=0 c=%0d",
                 i, redirect, target, fault, rs_count, ret_exp[i], 2 - i);
      end
    end
    do_req(2'b10, 5'd0, 8'd0, 1'b0);
    tests_run++;
    if ({redirect, target, fault, rs_count} !== {1'b0, 8'h00, 1'b1, 3'd0}) begin
      tests_failed++;
      $display("FAIL underflow: got r=%b t=%h f=%b c=%0d, want r=0 t=00 f=1 c=0",
               redirect, target, fault, rs_count);
    end
  endtask

  task automatic test_overflow;
    logic [D-1:0] ret_exp [4];
    ret_exp[0] = 8'd5; ret_exp[1] = 8'd4; ret_exp[2] = 8'd3; ret_exp[3] = 8'd2;
    for (int i = 0; i < 5; i++) begin
      do_req(2'b01, 5'd1, 8'(i), 1'b1);
      tests_run++;
      if ({redirect, target, fault, rs_count} !==
          {1'b1, 8'd22, (i == 4), 3'((i < 4) ? i + 1 : 4)}) begin
        tests_failed++;
        $display("FAIL ovf_call_%0d: got r=%b t=%0d f=%b c=%0d, want r=1 t=22 f=%0d c=%0d",
                 i, redirect, target, fault, rs_count, (i == 4), (i < 4) ? i + 1 : 4);
      end
    end
    for (int i = 0; i < 4; i++) begin
      do_req(2'b10, 5'd0, 8'd0, 1'b0);
      tests_run++;
      if ({redirect, target, fault} !== {1'b1, ret_exp[i], 1'b0}) begin
        tests_failed++;
        $display("FAIL ovf_return_%0d: got r=%b t=%0d f=%b, want r=1 t=%0d f=0",
                 i, redirect, target, fault, ret_exp[i]);
      end
    end
    tests_run++;
    if (rs_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL ovf_drain_count: got %0d, want 0", rs_count);
    end
  endtask

  task automatic test_back_to_back;
    do_write(5'd7, 8'd40, 1'b0);
    wr_en = 1'b1; wr_idx = 5'd7; wr_target = 8'd50; wr_rel = 1'b0;
    do_req(2'b00, 5'd7, 8'd0, 1'b1);
    tests_run++;
    if ({redirect, target} !== {1'b1, 8'd40}) begin
      tests_failed++;
      $display("FAIL collision_old: got r=%b t=%0d, want r=1 t=40", redirect, target);
    end
    do_req(2'b00, 5'd7, 8'd0, 1'b1);
    tests_run++;
    if ({redirect, target} !== {1'b1, 8'd50}) begin
      tests_failed++;
      $display("FAIL collision_new: got r=%b t=%0d, want r=1 t=50", redirect, target);
    end
  endtask

  task automatic test_reset_midstream;
    do_req(2'b01, 5'd1, 8'd30, 1'b1);
    tests_run++;
    if ({redirect, target, rs_count} !== {1'b1, 8'd22, 3'd1}) begin
      tests_failed++;
      $display("FAIL mid_call: got r=%b t=%0d c=%0d, want r=1 t=22 c=1",
               redirect, target, rs_count);
    end
    #1 reset = 1'b1;
    #1;
    tests_run++;
    if ({rsp_valid, redirect, target, fault, rs_count} !==
        {1'b1 ^ 1'b1, 1'b0, 8'h00, 1'b0, 3'd0}) begin
      tests_failed++;
      $display("FAIL mid_reset: got v=%b r=%b t=%h f=%b c=%0d, want all zero",
               rsp_valid, redirect, target, fault, rs_count);
    end
    #1 reset = 1'b0;
    do_req(2'b10, 5'd0, 8'd0, 1'b0);
    tests_run++;
    if ({rsp_valid, redirect, target, fault} !== {1'b1, 1'b0, 8'h00, 1'b1}) begin
      tests_failed++;
      $display("FAIL mid_return: got v=%b r=%b t=%h f=%b, want v=1 r=0 t=00 f=1",
               rsp_valid, redirect, target, fault);
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    reset = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_target = '0; wr_rel = 1'b0;
    req = 1'b0; req_kind = 2'b11; idx = '0; pc = '0; taken = 1'b0;
    test_reset;
    test_table;
    test_call_return;
    test_overflow;
    test_back_to_back;
    test_reset_midstream;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
